alu_pipe: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pipe_if.sv | 31 +++
 rtl/alu_pipe.sv | 127 ++++++++++++
 tb/tb_alu_pipe.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake bundle between an ALU producer/consumer pair and alu_pipe.
// The master drives operands and out_ready; the slave (the ALU) drives results.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic [WIDTH-1:0] ALU_Out_hi;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output in_valid, A, B, Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, ALU_Out_hi,
           flag_c, flag_z, flag_n, flag_v
  );

  modport slave (
    input  in_valid, A, B, Sel, out_ready,
    output in_ready, out_valid, ALU_Out, ALU_Out_hi,
           flag_c, flag_z, flag_n, flag_v
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops plus a
// WIDTH-step shift-add multiplier, results held until the consumer takes them.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_pipe_if.slave bus
);
  localparam int       CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] SEL_MUL = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL_RUN, OUT_HOLD} state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       out_q;
  logic [WIDTH-1:0]       hi_q;
  logic                   c_q, z_q, n_q, v_q;
  logic [WIDTH-1:0]       mcand_q;
  logic [2*WIDTH-1:0]     prod_q;
  logic [CW-1:0]          cnt_q;

  logic                   accept;
  logic [WIDTH:0]         sum_d;
  logic [WIDTH:0]         diff_d;
  logic [WIDTH-1:0]       res_d;
  logic                   c_d, v_d;
  logic [WIDTH:0]         step_sum;
  logic [2*WIDTH-1:0]     step_prod;

  assign bus.in_ready   = (state_q == IDLE) || ((state_q == OUT_HOLD) && bus.out_ready);
  assign bus.out_valid  = (state_q == OUT_HOLD);
  assign bus.ALU_Out    = out_q;
  assign bus.ALU_Out_hi = hi_q;
  assign bus.flag_c     = c_q;
  assign bus.flag_z     = z_q;
  assign bus.flag_n     = n_q;
  assign bus.flag_v     = v_q;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    sum_d  = {1'b0, bus.A} + {1'b0, bus.B};
    diff_d = {1'b0, bus.A} - {1'b0, bus.B};
    res_d  = '0;
    c_d    = 1'b0;
    v_d    = 1'b0;
    case (bus.Sel)
      3'b000: begin
        res_d = sum_d[WIDTH-1:0];
        c_d   = sum_d[WIDTH];
        v_d   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_d[WIDTH-1] != bus.A[WIDTH-1]);
      end
      3'b001: begin
        // The extra top bit of the widened difference is the borrow.
        res_d = diff_d[WIDTH-1:0];
        c_d   = diff_d[WIDTH];
        v_d   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_d[WIDTH-1] != bus.A[WIDTH-1]);
      end
      3'b010: res_d = bus.A & bus.B;
      3'b011: res_d = bus.A | bus.B;
      3'b100: res_d = bus.A ^ bus.B;
      3'b110: begin
        res_d = {bus.A[WIDTH-2:0], 1'b0};
        c_d   = bus.A[WIDTH-1];
      end
      3'b111: begin
        res_d = {1'b0, bus.A[WIDTH-1:1]};
        c_d   = bus.A[0];
      end
      default: ;
    endcase
  end

  // Multiplier step: multiplier sits in the low half and is shifted out as
  // the accumulated high half shifts in from above.
  assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign step_prod = {step_sum, prod_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      hi_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      if (bus.Sel == SEL_MUL) begin
        mcand_q <= bus.A;
        prod_q  <= {{WIDTH{1'b0}}, bus.B};
        cnt_q   <= CW'(WIDTH - 1);
        state_q <= MUL_RUN;
      end else begin
        out_q   <= res_d;
        hi_q    <= '0;
        c_q     <= c_d;
        z_q     <= (res_d == '0);
        n_q     <= res_d[WIDTH-1];
        v_q     <= v_d;
        state_q <= OUT_HOLD;
      end
    end else begin
      case (state_q)
        MUL_RUN: begin
          prod_q <= step_prod;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            out_q   <= step_prod[WIDTH-1:0];
            hi_q    <= step_prod[2*WIDTH-1:WIDTH];
            c_q     <= |step_prod[2*WIDTH-1:WIDTH];
            z_q     <= (step_prod[WIDTH-1:0] == '0);
            n_q     <= step_prod[WIDTH-1];
            v_q     <= 1'b0;
            state_q <= OUT_HOLD;
          end
        end
        OUT_HOLD: if (bus.out_ready) state_q <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed scenarios plus a
// randomized stream with stalls scored against an arithmetic reference.
module tb_alu_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_pipe_if #(.WIDTH(W)) bus();
  alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
  } res_t;

  function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
    res_t r;
    int ua, ub, sa, sb, t;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = 0;
    r  = '0;
    case (s)
      3'd0: begin t = ua + ub; r.c = (t > 255); r.v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin t = ua - ub; r.c = (ua < ub); r.v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: t = int'(a & b);
      3'd3: t = int'(a | b);
      3'd4: t = int'(a ^ b);
      3'd5: begin t = ua * ub; r.hi = W'(t / 256); r.c = (t >= 256); end
      3'd6: begin t = ua * 2; r.c = (ua >= 128); end
      default: begin t = ua / 2; r.c = (ua % 2 == 1); end
    endcase
    r.lo = W'(t & 255);
    r.z  = (r.lo == '0);
    r.n  = (r.lo >= W'(128));
    return r;
  endfunction

  function automatic res_t get_obs();
    return {bus.ALU_Out_hi, bus.ALU_Out, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v};
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
    bus.A = a; bus.B = b; bus.Sel = s; bus.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++; n_err++;
    $display("FAIL send_timeout: in_ready stayed 0 for 64 cycles, required 1");
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Sel = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, get_obs()} !== {2'b01, 20'h0}) begin
      n_err++;
      $display("FAIL reset_state: got v/r/obs %b %b %h required 0 1 00000", bus.out_valid, bus.in_ready, get_obs());
    end
    rst_n = 1'b1;
    send(8'hFF, 8'hFF, 3'd0);
    @(negedge clk);
    n_cmp++;
    if (get_obs() !== ref_op(8'hFF, 8'hFF, 3'd0)) begin
      n_err++;
      $display("FAIL pre_reset_add: got %h required %h", get_obs(), ref_op(8'hFF, 8'hFF, 3'd0));
    end
    @(posedge clk); #1;
    send(8'h0F, 8'h0F, 3'd5);
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, get_obs()} !== {2'b01, 20'h0}) begin
      n_err++;
      $display("FAIL reset_mid_mul: got v/r/obs %b %b %h required 0 1 00000", bus.out_valid, bus.in_ready, get_obs());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_discard: out_valid seen %b after reset, required 0", seen);
    end
  endtask

  task automatic test_add_sub();
    bus.out_ready = 1'b1;
    send(8'h7F, 8'h01, 3'd0);
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, get_obs()} !== {1'b1, 8'h00, 8'h80, 4'b0011}) begin
      n_err++;
      $display("FAIL add_7f_01: got v=%b obs=%h required v=1 obs=%h", bus.out_valid, get_obs(), {8'h00, 8'h80, 4'b0011});
    end
    @(posedge clk); #1;
    send(8'h00, 8'h01, 3'd1);
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, get_obs()} !== {1'b1, 8'h00, 8'hFF, 4'b1010}) begin
      n_err++;
      $display("FAIL sub_00_01: got v=%b obs=%h required v=1 obs=%h", bus.out_valid, get_obs(), {8'h00, 8'hFF, 4'b1010});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int   lat;
    logic ready_bad;
    bus.out_ready = 1'b1;
    send(8'hFF, 8'hFF, 3'd5);
    lat = 1;
    ready_bad = 1'b0;
    @(negedge clk);
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) ready_bad = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_cmp++;
    if (lat != 9) begin
      n_err++;
      $display("FAIL mul_latency: got %0d cycles required 9", lat);
    end
    n_cmp++;
    if (ready_bad !== 1'b0) begin
      n_err++;
      $display("FAIL mul_in_ready: in_ready high during multiply (%b), required 0", ready_bad);
    end
    n_cmp++;
    if (get_obs() !== {8'hFE, 8'h01, 4'b1000}) begin
      n_err++;
      $display("FAIL mul_ff_ff: got %h required %h", get_obs(), {8'hFE, 8'h01, 4'b1000});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(8'hAA, 8'hAA, 3'd4);
    bus.A = 8'h01; bus.B = 8'h02; bus.Sel = 3'd0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, get_obs()} !== {2'b10, 8'h00, 8'h00, 4'b0100}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v/r/obs %b %b %h required 1 0 %h", i, bus.out_valid, bus.in_ready, get_obs(), {8'h00, 8'h00, 4'b0100});
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release_ready: got %b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, get_obs()} !== {1'b1, 8'h00, 8'h03, 4'b0000}) begin
      n_err++;
      $display("FAIL stall_next_op: got v=%b obs=%h required v=1 obs=%h", bus.out_valid, get_obs(), {8'h00, 8'h03, 4'b0000});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] op_a  [4] = '{8'hF0, 8'hF0, 8'h81, 8'h01};
    logic [W-1:0] op_b  [4] = '{8'h3C, 8'h0F, 8'h00, 8'h00};
    logic [2:0]   op_s  [4] = '{3'd2, 3'd3, 3'd6, 3'd7};
    logic [W-1:0] exp_lo[4] = '{8'h30, 8'hFF, 8'h02, 8'h00};
    logic [1:0]   exp_cz[4] = '{2'b00, 2'b00, 2'b10, 2'b11};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus.A = op_a[i]; bus.B = op_b[i]; bus.Sel = op_s[i]; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 4) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL stream_ready[%0d]: got %b required 1", i, bus.in_ready);
        end
      end
      if (i > 0) begin
        n_cmp++;
        if ({bus.out_valid, bus.ALU_Out, bus.flag_c, bus.flag_z} !== {1'b1, exp_lo[i-1], exp_cz[i-1]}) begin
          n_err++;
          $display("FAIL stream_result[%0d]: got v=%b out=%h cz=%b%b required v=1 out=%h cz=%b",
                   i - 1, bus.out_valid, bus.ALU_Out, bus.flag_c, bus.flag_z, exp_lo[i-1], exp_cz[i-1]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    res_t q[$];
    res_t exp_r;
    res_t prev_obs;
    logic prev_hold;
    logic have;
    int   sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    have = 1'b0; prev_hold = 1'b0; prev_obs = '0;
    while (got < 1000 && cyc < 30000) begin
      if (!have && sent < 1000 && $urandom_range(3) != 0) begin
        bus.A   = W'($urandom);
        bus.B   = W'($urandom);
        bus.Sel = 3'($urandom_range(7));
        have    = 1'b1;
      end
      bus.in_valid  = have;
      bus.out_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      if (prev_hold) begin
        n_cmp++;
        if ({bus.out_valid, get_obs()} !== {1'b1, prev_obs}) begin
          n_err++;
          $display("FAIL rand_hold: got v=%b obs=%h required v=1 obs=%h", bus.out_valid, get_obs(), prev_obs);
        end
      end
      n_cmp++;
      if (bus.out_valid && bus.in_ready && !bus.out_ready) begin
        n_err++;
        $display("FAIL rand_invariant: out_valid=1 in_ready=1 with out_ready=0, required in_ready=0");
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra: result %h delivered with no op outstanding", get_obs());
        end else begin
          exp_r = q.pop_front();
          if (get_obs() !== exp_r) begin
            n_err++;
            $display("FAIL rand_result[%0d]: got %h required %h", got, get_obs(), exp_r);
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_op(bus.A, bus.B, bus.Sel));
        have = 1'b0;
        sent++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_obs  = get_obs();
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (got != 1000 || sent != 1000 || q.size() != 0) begin
      n_err++;
      $display("FAIL rand_count: sent=%0d delivered=%0d pending=%0d required 1000/1000/0", sent, got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
